// File: rtl/g729_pkg.sv
// g729_pkg: constants shared by the G.729 datapath blocks.
//   M, L          filter order and samples per subframe
//   state_t       syn_filt controller state encoding
//   ROUND_K       rounding constant added before taking the high half
//   SYN_SHIFT     left shift that undoes the Q12 coefficient scaling
//   BLK_IDX_W     index width inside a 16-word aligned coefficient block
//   blk_addr      forms a block word address from base bits [10:4] and index
package g729_pkg;

  localparam int M = 10;
  localparam int L = 40;

  localparam logic [31:0] ROUND_K   = 32'h0000_8000;
  localparam logic [15:0] SYN_SHIFT = 16'd3;

  localparam int BLK_IDX_W = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOADM_RD,
    S_LOADM_CAP,
    S_RD_A0,
    S_RD_X,
    S_MUL0,
    S_RD_AJ,
    S_MSU,
    S_OUT,
    S_UPD,
    S_DONE
  } state_t;

  function automatic logic [10:0] blk_addr(input logic [6:0] base_hi,
                                           input logic [BLK_IDX_W-1:0] idx);
    return {base_hi, idx};
  endfunction

endpackage

// File: rtl/syn_hist.sv
// syn_hist: M x 16-bit history register for the synthesis filter.
// hist[i] (i = 1..M) holds y[n-i].
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears all taps)
//   load_en      write load_data into tap load_idx (1..M)
//   load_idx     tap index for load
//   load_data    word to load
//   shift_en     shift hist[i] <= hist[i-1], hist[1] <= shift_data (wins over load)
//   shift_data   new y[n] entering tap 1
//   hist_flat    all taps, hist[i] at bits [16*i-1 -: 16]
module syn_hist
  import g729_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [3:0]        load_idx,
  input  logic [15:0]       load_data,
  input  logic              shift_en,
  input  logic [15:0]       shift_data,
  output logic [16*M-1:0]   hist_flat
);

  // chain slice 0 is the shift input, slice i is tap i
  logic [16*(M+1)-1:0] chain;

  assign chain[15:0] = shift_data;

  generate
    for (genvar gi = 1; gi <= M; gi++) begin : g_tap
      logic [15:0] tap_q;
      logic [15:0] tap_d;

      always_comb begin
        tap_d = tap_q;
        if (shift_en) begin
          tap_d = chain[16*(gi-1) +: 16];
        end else if (load_en && (load_idx == 4'(gi))) begin
          tap_d = load_data;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          tap_q <= '0;
        end else begin
          tap_q <= tap_d;
        end
      end

      assign chain[16*gi +: 16] = tap_q;
    end
  endgenerate

  assign hist_flat = chain[16*(M+1)-1:16];

endmodule

// File: rtl/syn_filt.sv
// syn_filt: G.729 LPC synthesis filter 1/A(z) over one subframe.
//   y[n] = round((x[n]*a[0] - sum_{j=1..M} a[j]*y[n-j]) << 3)
// Arithmetic goes through the shared saturating L_mult/L_sub/L_shl/L_add units.
// Optional feature macro: SYN_FILT_UPDATE_EN -- adds the update port and the
// UPD state, which writes the last M outputs back to the filter memory.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   update              (SYN_FILT_UPDATE_EN only) write back filter memory
//   start / done        one-cycle request (IDLE only) / completion pulse
//   A, X, Y, MEM        coefficient block, input, output, filter memory bases
//   readAddr / readIn   scratch read port, one-cycle read latency
//   writeAddr/writeOut/writeEn  scratch write port (sign-extended 16-bit data)
//   L_*_a/_b / L_*_in   operand outputs and result inputs of the shared units
module syn_filt
  import g729_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
`ifdef SYN_FILT_UPDATE_EN
  input  logic        update,
`endif
  input  logic        start,
  output logic        done,
  input  logic [10:0] A,
  input  logic [10:0] X,
  input  logic [10:0] Y,
  input  logic [10:0] MEM,
  output logic [10:0] readAddr,
  input  logic [31:0] readIn,
  output logic [10:0] writeAddr,
  output logic [31:0] writeOut,
  output logic        writeEn,
  output logic [15:0] L_mult_a,
  output logic [15:0] L_mult_b,
  input  logic [31:0] L_mult_in,
  output logic [31:0] L_sub_a,
  output logic [31:0] L_sub_b,
  input  logic [31:0] L_sub_in,
  output logic [31:0] L_shl_a,
  output logic [15:0] L_shl_b,
  input  logic [31:0] L_shl_in,
  output logic [31:0] L_add_a,
  output logic [31:0] L_add_b,
  input  logic [31:0] L_add_in
);

  state_t      state_q, state_d;
  logic [5:0]  n_q, n_d;
  logic [3:0]  idx_q, idx_d;     // k during LOADM/UPD, j during the MAC loop
  logic [31:0] acc_q, acc_d;
  logic [15:0] coef_q, coef_d;
`ifdef SYN_FILT_UPDATE_EN
  logic        upd_q, upd_d;
`endif

  logic            h_load_en;
  logic [3:0]      h_load_idx;
  logic            h_shift_en;
  logic [16*M-1:0] hist_flat;
  logic [3:0]      hist_sel_idx;
  logic [15:0]     hist_sel;
  logic [15:0]     y_w;
  logic            unused_bits;

  assign y_w         = L_add_in[31:16];
  assign unused_bits = ^{readIn[31:16], L_add_in[15:0], A[3:0]};

  syn_hist u_hist (
    .clk        (clk),
    .reset      (reset),
    .load_en    (h_load_en),
    .load_idx   (h_load_idx),
    .load_data  (readIn[15:0]),
    .shift_en   (h_shift_en),
    .shift_data (y_w),
    .hist_flat  (hist_flat)
  );

  // MSU reads hist[j]; UPD drains hist[M-k] so memory ends up oldest-first
  assign hist_sel_idx = (state_q == S_UPD) ? (4'(M) - idx_q) : idx_q;

  always_comb begin
    hist_sel = '0;
    for (int i = 1; i <= M; i++) begin
      if (hist_sel_idx == 4'(i)) begin
        hist_sel = hist_flat[16*(i-1) +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      coef_q  <= '0;
`ifdef SYN_FILT_UPDATE_EN
      upd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      coef_q  <= coef_d;
`ifdef SYN_FILT_UPDATE_EN
      upd_q   <= upd_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    coef_d     = coef_q;
`ifdef SYN_FILT_UPDATE_EN
    upd_d      = upd_q;
`endif
    done       = 1'b0;
    readAddr   = '0;
    writeAddr  = '0;
    writeOut   = '0;
    writeEn    = 1'b0;
    L_mult_a   = '0;
    L_mult_b   = '0;
    L_sub_a    = '0;
    L_sub_b    = '0;
    L_shl_a    = '0;
    L_shl_b    = '0;
    L_add_a    = '0;
    L_add_b    = '0;
    h_load_en  = 1'b0;
    h_load_idx = '0;
    h_shift_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef SYN_FILT_UPDATE_EN
          upd_d = update;
`endif
          idx_d   = '0;
          state_d = S_LOADM_RD;
        end
      end
      S_LOADM_RD: begin
        readAddr = MEM + {7'd0, idx_q};
        state_d  = S_LOADM_CAP;
      end
      S_LOADM_CAP: begin
        // mem[k] is y[k-M], i.e. history tap M-k
        h_load_en  = 1'b1;
        h_load_idx = 4'(M) - idx_q;
        if (idx_q == 4'(M-1)) begin
          n_d     = '0;
          idx_d   = '0;
          state_d = S_RD_A0;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_LOADM_RD;
        end
      end
      S_RD_A0: begin
        readAddr = blk_addr(A[10:4], 4'd0);
        state_d  = S_RD_X;
      end
      S_RD_X: begin
        coef_d   = readIn[15:0];
        readAddr = X + {5'd0, n_q};
        state_d  = S_MUL0;
      end
      S_MUL0: begin
        L_mult_a = readIn[15:0];
        L_mult_b = coef_q;
        acc_d    = L_mult_in;
        idx_d    = 4'd1;
        state_d  = S_RD_AJ;
      end
      S_RD_AJ: begin
        readAddr = blk_addr(A[10:4], idx_q);
        state_d  = S_MSU;
      end
      S_MSU: begin
        L_mult_a = readIn[15:0];
        L_mult_b = hist_sel;
        L_sub_a  = acc_q;
        L_sub_b  = L_mult_in;
        acc_d    = L_sub_in;
        if (idx_q == 4'(M)) begin
          state_d = S_OUT;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_RD_AJ;
        end
      end
      S_OUT: begin
        L_shl_a    = acc_q;
        L_shl_b    = SYN_SHIFT;
        L_add_a    = L_shl_in;
        L_add_b    = ROUND_K;
        writeAddr  = Y + {5'd0, n_q};
        writeOut   = {{16{y_w[15]}}, y_w};
        writeEn    = 1'b1;
        h_shift_en = 1'b1;
        n_d        = n_q + 6'd1;
        if (n_q == 6'(L-1)) begin
`ifdef SYN_FILT_UPDATE_EN
          if (upd_q) begin
            idx_d   = '0;
            state_d = S_UPD;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_RD_A0;
        end
      end
`ifdef SYN_FILT_UPDATE_EN
      S_UPD: begin
        writeAddr = MEM + {7'd0, idx_q};
        writeOut  = {{16{hist_sel[15]}}, hist_sel};
        writeEn   = 1'b1;
        if (idx_q == 4'(M-1)) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
